// File: rtl/axi_mem_responder.sv
// AXI4 subordinate that serves AW/W/B and AR/R bursts from a flip-flop memory array.
// Optional macro AXI_MEM_RESPONDER_RANGE_ERR_EN: beats addressing past the array return SLVERR.
module axi_mem_responder #(
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned NumWords     = 256,
    localparam int unsigned StrbWidth   = AxiDataWidth / 8,
    localparam int unsigned AwWidth     = AxiIdWidth + AxiAddrWidth + 36,
    localparam int unsigned WWidth      = AxiDataWidth + StrbWidth + 2,
    localparam int unsigned ArWidth     = AxiIdWidth + AxiAddrWidth + 30,
    localparam int unsigned ReqWidth    = AwWidth + WWidth + ArWidth + 5,
    localparam int unsigned BWidth      = AxiIdWidth + 3,
    localparam int unsigned RWidth      = AxiIdWidth + AxiDataWidth + 4,
    localparam int unsigned RespWidth   = BWidth + RWidth + 5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [ReqWidth-1:0]  axi_req_i,
    output logic [RespWidth-1:0] axi_resp_o
);

    localparam int unsigned OffW = $clog2(StrbWidth);
    localparam int unsigned IdxW = $clog2(NumWords);
    localparam logic [AxiAddrWidth-1:0] AddrOne  = {{(AxiAddrWidth-1){1'b0}}, 1'b1};
    localparam logic [AxiAddrWidth-1:0] AddrZero = {AxiAddrWidth{1'b0}};
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [5:0]              atop;
        logic                    user;
    } aw_chan_t;

    typedef struct packed {
        logic [AxiDataWidth-1:0] data;
        logic [StrbWidth-1:0]    strb;
        logic                    last;
        logic                    user;
    } w_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic                    user;
    } ar_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0] id;
        logic [1:0]            resp;
        logic                  user;
    } b_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiDataWidth-1:0] data;
        logic [1:0]              resp;
        logic                    last;
        logic                    user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    // Address of the following beat; WRAP windows are (len+1)*2^size bytes and power-of-two aligned.
    function automatic logic [AxiAddrWidth-1:0] next_addr(
        input logic [AxiAddrWidth-1:0] addr,
        input logic [7:0]              len,
        input logic [2:0]              size,
        input logic [1:0]              burst
    );
        logic [AxiAddrWidth-1:0] step;
        logic [AxiAddrWidth-1:0] aligned;
        logic [AxiAddrWidth-1:0] wrap_mask;
        logic [AxiAddrWidth-1:0] result;
        step      = AddrOne << size;
        aligned   = addr & ~(step - AddrOne);
        wrap_mask = (({{(AxiAddrWidth-8){1'b0}}, len} + AddrOne) << size) - AddrOne;
        case (burst)
            BurstFixed: result = addr;
            BurstIncr:  result = aligned + step;
            BurstWrap:  result = (addr & ~wrap_mask) | ((aligned + step) & wrap_mask);
            default:    result = addr;
        endcase
        return result;
    endfunction

    req_t  req_s;
    resp_t resp_s;
    logic  unused_s;

    w_state_e w_state_r, w_state_next_s;
    r_state_e r_state_r, r_state_next_s;

    logic [AxiIdWidth-1:0]   aw_id_r;
    logic [AxiAddrWidth-1:0] aw_addr_r;
    logic [7:0]              aw_len_r;
    logic [2:0]              aw_size_r;
    logic [1:0]              aw_burst_r;
    logic                    aw_atop_r;
    logic [7:0]              w_cnt_r;
    logic                    w_err_r;

    logic [AxiIdWidth-1:0]   ar_id_r;
    logic [AxiAddrWidth-1:0] ar_addr_r;
    logic [7:0]              ar_len_r;
    logic [2:0]              ar_size_r;
    logic [1:0]              ar_burst_r;
    logic [7:0]              r_cnt_r;

    logic [AxiDataWidth-1:0] mem_r [NumWords];

    logic aw_ready_s, w_ready_s, b_valid_s, ar_ready_s, r_valid_s;
    logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic w_final_s, w_beat_err_s, w_range_err_s, mem_we_s;
    logic r_last_s, r_range_err_s;
    logic [IdxW-1:0]         w_idx_s, r_idx_s;
    logic [AxiDataWidth-1:0] r_data_s;

    assign req_s      = axi_req_i;
    assign axi_resp_o = resp_s;

    assign unused_s = ^{req_s.aw.lock, req_s.aw.cache, req_s.aw.prot, req_s.aw.qos,
                        req_s.aw.region, req_s.aw.user, req_s.w.user, req_s.ar.lock,
                        req_s.ar.cache, req_s.ar.prot, req_s.ar.qos, req_s.ar.region,
                        req_s.ar.user};

    assign aw_hs_s = req_s.aw_valid & aw_ready_s;
    assign w_hs_s  = req_s.w_valid & w_ready_s;
    assign b_hs_s  = b_valid_s & req_s.b_ready;
    assign ar_hs_s = req_s.ar_valid & ar_ready_s;
    assign r_hs_s  = r_valid_s & req_s.r_ready;

    assign w_idx_s   = aw_addr_r[OffW +: IdxW];
    assign r_idx_s   = ar_addr_r[OffW +: IdxW];
    assign w_final_s = (w_cnt_r == aw_len_r);
    assign r_last_s  = (r_cnt_r == ar_len_r);

`ifdef AXI_MEM_RESPONDER_RANGE_ERR_EN
    assign w_range_err_s = (aw_addr_r >> (OffW + IdxW)) != AddrZero;
    assign r_range_err_s = (ar_addr_r >> (OffW + IdxW)) != AddrZero;
`else
    assign w_range_err_s = 1'b0;
    assign r_range_err_s = 1'b0;
`endif

    // The beat counter decides the burst end; a w.last that disagrees only taints the response.
    assign w_beat_err_s = (req_s.w.last != w_final_s) | w_range_err_s;
    assign mem_we_s     = w_hs_s & ~aw_atop_r & ~w_range_err_s;
    assign r_data_s     = r_range_err_s ? {AxiDataWidth{1'b0}} : mem_r[r_idx_s];

    // Write FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_r <= W_IDLE;
        end else begin
            w_state_r <= w_state_next_s;
        end
    end

    // Write FSM next-state logic
    always_comb begin
        w_state_next_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s) w_state_next_s = W_DATA;
                else         w_state_next_s = W_IDLE;
            end
            W_DATA: begin
                if (w_hs_s && w_final_s) w_state_next_s = W_RESP;
                else                     w_state_next_s = W_DATA;
            end
            W_RESP: begin
                if (b_hs_s) w_state_next_s = W_IDLE;
                else        w_state_next_s = W_RESP;
            end
            default: w_state_next_s = W_IDLE;
        endcase
    end

    // Write FSM channel handshake outputs
    always_comb begin
        aw_ready_s = 1'b0;
        w_ready_s  = 1'b0;
        b_valid_s  = 1'b0;
        case (w_state_r)
            W_IDLE:  aw_ready_s = 1'b1;
            W_DATA:  w_ready_s  = 1'b1;
            W_RESP:  b_valid_s  = 1'b1;
            default: aw_ready_s = 1'b0;
        endcase
    end

    // Write burst context, beat counter and sticky error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_id_r    <= {AxiIdWidth{1'b0}};
            aw_addr_r  <= AddrZero;
            aw_len_r   <= 8'd0;
            aw_size_r  <= 3'd0;
            aw_burst_r <= 2'b00;
            aw_atop_r  <= 1'b0;
            w_cnt_r    <= 8'd0;
            w_err_r    <= 1'b0;
        end else if (aw_hs_s) begin
            aw_id_r    <= req_s.aw.id;
            aw_addr_r  <= req_s.aw.addr;
            aw_len_r   <= req_s.aw.len;
            aw_size_r  <= req_s.aw.size;
            aw_burst_r <= req_s.aw.burst;
            aw_atop_r  <= |req_s.aw.atop;
            w_cnt_r    <= 8'd0;
            w_err_r    <= |req_s.aw.atop;
        end else if (w_hs_s) begin
            aw_addr_r <= next_addr(aw_addr_r, aw_len_r, aw_size_r, aw_burst_r);
            w_cnt_r   <= w_cnt_r + 8'd1;
            w_err_r   <= w_err_r | w_beat_err_s;
        end
    end

    // Storage array with byte-lane write enables
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumWords; i++) begin
                mem_r[i] <= {AxiDataWidth{1'b0}};
            end
        end else if (mem_we_s) begin
            for (int b = 0; b < StrbWidth; b++) begin
                if (req_s.w.strb[b]) begin
                    mem_r[w_idx_s][b*8 +: 8] <= req_s.w.data[b*8 +: 8];
                end
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_r <= R_IDLE;
        end else begin
            r_state_r <= r_state_next_s;
        end
    end

    // Read FSM next-state logic
    always_comb begin
        r_state_next_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) r_state_next_s = R_DATA;
                else         r_state_next_s = R_IDLE;
            end
            R_DATA: begin
                if (r_hs_s && r_last_s) r_state_next_s = R_IDLE;
                else                    r_state_next_s = R_DATA;
            end
            default: r_state_next_s = R_IDLE;
        endcase
    end

    // Read FSM channel handshake outputs
    always_comb begin
        ar_ready_s = 1'b0;
        r_valid_s  = 1'b0;
        case (r_state_r)
            R_IDLE:  ar_ready_s = 1'b1;
            R_DATA:  r_valid_s  = 1'b1;
            default: ar_ready_s = 1'b0;
        endcase
    end

    // Read burst context and beat counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ar_id_r    <= {AxiIdWidth{1'b0}};
            ar_addr_r  <= AddrZero;
            ar_len_r   <= 8'd0;
            ar_size_r  <= 3'd0;
            ar_burst_r <= 2'b00;
            r_cnt_r    <= 8'd0;
        end else if (ar_hs_s) begin
            ar_id_r    <= req_s.ar.id;
            ar_addr_r  <= req_s.ar.addr;
            ar_len_r   <= req_s.ar.len;
            ar_size_r  <= req_s.ar.size;
            ar_burst_r <= req_s.ar.burst;
            r_cnt_r    <= 8'd0;
        end else if (r_hs_s) begin
            ar_addr_r <= next_addr(ar_addr_r, ar_len_r, ar_size_r, ar_burst_r);
            r_cnt_r   <= r_cnt_r + 8'd1;
        end
    end

    // Response struct assembly
    always_comb begin
        resp_s.aw_ready = aw_ready_s;
        resp_s.ar_ready = ar_ready_s;
        resp_s.w_ready  = w_ready_s;
        resp_s.b_valid  = b_valid_s;
        resp_s.b.id     = aw_id_r;
        resp_s.b.resp   = w_err_r ? RespSlvErr : RespOkay;
        resp_s.b.user   = 1'b0;
        resp_s.r_valid  = r_valid_s;
        resp_s.r.id     = ar_id_r;
        resp_s.r.data   = r_data_s;
        resp_s.r.resp   = r_range_err_s ? RespSlvErr : RespOkay;
        resp_s.r.last   = r_last_s;
        resp_s.r.user   = 1'b0;
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: randomized and directed bursts against a byte-array model.
module tb_axi_mem_responder;

    localparam int unsigned NW = 256;
    localparam int unsigned SB = 8;
    localparam int unsigned MEM_BYTES = NW * SB;
`ifdef AXI_MEM_RESPONDER_RANGE_ERR_EN
    localparam bit RangeEn = 1'b1;
`else
    localparam bit RangeEn = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
        logic lock; logic [3:0] cache; logic [2:0] prot; logic [3:0] qos; logic [3:0] region;
        logic [5:0] atop; logic user;
    } aw_chan_t;
    typedef struct packed { logic [63:0] data; logic [7:0] strb; logic last; logic user; } w_chan_t;
    typedef struct packed {
        logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
        logic lock; logic [3:0] cache; logic [2:0] prot; logic [3:0] qos; logic [3:0] region;
        logic user;
    } ar_chan_t;
    typedef struct packed { logic [3:0] id; logic [1:0] resp; logic user; } b_chan_t;
    typedef struct packed { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; logic user; } r_chan_t;
    typedef struct packed {
        aw_chan_t aw; logic aw_valid; w_chan_t w; logic w_valid; logic b_ready;
        ar_chan_t ar; logic ar_valid; logic r_ready;
    } req_t;
    typedef struct packed {
        logic aw_ready; logic ar_ready; logic w_ready; logic b_valid; b_chan_t b;
        logic r_valid; r_chan_t r;
    } resp_t;

    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;

    logic  clk = 1'b0;
    logic  rst_n;
    req_t  req;
    resp_t resp;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_mem [MEM_BYTES];
    logic [63:0] wr_data [256];
    logic [7:0]  wr_strb [256];
    b_exp_t b_q[$];
    r_exp_t r_q[$];

    always #5 clk = ~clk;

    axi_mem_responder dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .axi_req_i (req),
        .axi_resp_o(resp)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    // Byte address of beat n following the AXI burst address rules.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int n, input int size,
                                              input int len, input logic [1:0] burst);
        longint nb, aligned, wsz, lower, a;
        nb = longint'(1) << size;
        aligned = (longint'(start) / nb) * nb;
        wsz = nb * (len + 1);
        if (burst == 2'b00 || n == 0) return start;
        a = aligned + n * nb;
        if (burst == 2'b10) begin
            lower = (longint'(start) / wsz) * wsz;
            if (a >= lower + wsz) a = a - wsz;
        end
        return a[31:0];
    endfunction

    function automatic int unsigned word_base(input logic [31:0] a);
        return ((a / SB) % NW) * SB;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        int unsigned base = word_base(a);
        for (int l = 0; l < SB; l++) if (s[l]) ref_mem[base + l] = d[l*8 +: 8];
    endfunction

    function automatic logic [63:0] model_read(input logic [31:0] a);
        logic [63:0] d;
        int unsigned base = word_base(a);
        for (int l = 0; l < SB; l++) d[l*8 +: 8] = ref_mem[base + l];
        return d;
    endfunction

    task automatic wait_neg(input int which, input string name);
        int c = 0;
        logic rdy;
        do begin
            @(negedge clk);
            c++;
            case (which)
                0: rdy = resp.aw_ready;
                1: rdy = resp.w_ready;
                2: rdy = resp.b_valid;
                default: rdy = resp.ar_ready;
            endcase
        end while (!rdy && c < 100);
        if (!rdy) timeout(name);
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input int size, input logic [1:0] burst,
                            input logic [5:0] atop, input logic [3:0] id, input int bad_last,
                            input int b_hold, input bit chk_lat);
        logic err;
        logic last_n;
        logic [31:0] a;
        logic [1:0] exp_resp;
        err = (atop != 6'd0);
        for (int n = 0; n <= len; n++) begin
            a = beat_addr(addr, n, size, len, burst);
            last_n = (bad_last < 0) ? (n == len) : (n == bad_last);
            if (last_n != (n == len)) err = 1'b1;
            if (RangeEn && a >= MEM_BYTES) err = 1'b1;
            else if (atop == 6'd0) model_write(a, wr_data[n], wr_strb[n]);
        end
        exp_resp = err ? 2'b10 : 2'b00;
        b_q.push_back('{id, exp_resp});

        req.aw = '0;
        req.aw.id = id; req.aw.addr = addr; req.aw.len = 8'(len);
        req.aw.size = 3'(size); req.aw.burst = burst; req.aw.atop = atop;
        req.aw_valid = 1'b1;
        wait_neg(0, "aw_handshake");
        req.aw_valid = 1'b0;
        for (int n = 0; n <= len; n++) begin
            req.w_valid = 1'b0;
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            req.w.data = wr_data[n];
            req.w.strb = wr_strb[n];
            req.w.last = (bad_last < 0) ? (n == len) : (n == bad_last);
            req.w.user = 1'b0;
            req.w_valid = 1'b1;
            wait_neg(1, "w_handshake");
        end
        req.w_valid = 1'b0;
        req.b_ready = 1'b0;
        if (chk_lat) begin
            @(negedge clk);
            check("b_valid_latency", resp.b_valid, 1'b1);
            @(posedge clk);
            #1;
        end
        if (b_hold > 0) req.aw_valid = 1'b1;
        for (int h = 0; h < b_hold; h++) begin
            @(negedge clk);
            check("b_hold_valid", resp.b_valid, 1'b1);
            check("b_hold_id", resp.b.id, id);
            check("b_hold_resp", resp.b.resp, exp_resp);
            check("b_hold_no_aw", resp.aw_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        req.aw_valid = 1'b0;
        req.b_ready = 1'b1;
        wait_neg(2, "b_handshake");
        req.b_ready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input int size, input logic [1:0] burst,
                           input logic [3:0] id, input int r_hold, input bit chk_lat, input bit cont);
        logic [31:0] a;
        r_exp_t e;
        r_exp_t first;
        int beats;
        int cyc;
        for (int n = 0; n <= len; n++) begin
            a = beat_addr(addr, n, size, len, burst);
            e.id = id;
            e.last = (n == len);
            if (RangeEn && a >= MEM_BYTES) begin
                e.data = 64'd0; e.resp = 2'b10;
            end else begin
                e.data = model_read(a); e.resp = 2'b00;
            end
            if (n == 0) first = e;
            r_q.push_back(e);
        end
        req.ar = '0;
        req.ar.id = id; req.ar.addr = addr; req.ar.len = 8'(len);
        req.ar.size = 3'(size); req.ar.burst = burst;
        req.ar_valid = 1'b1;
        req.r_ready = 1'b0;
        wait_neg(3, "ar_handshake");
        req.ar_valid = 1'b0;
        if (chk_lat) begin
            @(negedge clk);
            check("r_valid_latency", resp.r_valid, 1'b1);
            @(posedge clk);
            #1;
        end
        if (r_hold > 0) req.ar_valid = 1'b1;
        for (int h = 0; h < r_hold; h++) begin
            @(negedge clk);
            check("r_hold_valid", resp.r_valid, 1'b1);
            check("r_hold_data", resp.r.data, first.data);
            check("r_hold_id", resp.r.id, id);
            check("r_hold_no_ar", resp.ar_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        req.ar_valid = 1'b0;
        beats = 0;
        cyc = 0;
        while (beats <= len && cyc < 2000) begin
            req.r_ready = cont ? 1'b1 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            cyc++;
            if (resp.r_valid && req.r_ready) beats++;
            @(posedge clk);
            #1;
        end
        req.r_ready = 1'b0;
        if (beats <= len) timeout("r_burst");
        if (cont) check("r_beats_per_cycle", 64'(cyc), 64'(len + 1));
    endtask

    // B channel scoreboard monitor
    always @(negedge clk) begin
        b_exp_t e;
        if (rst_n && resp.b_valid && req.b_ready) begin
            if (b_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: got id %h with no response outstanding", resp.b.id);
            end else begin
                e = b_q.pop_front();
                check("b_id", resp.b.id, e.id);
                check("b_resp", resp.b.resp, e.resp);
            end
        end
    end

    // R channel scoreboard monitor
    always @(negedge clk) begin
        r_exp_t e;
        if (rst_n && resp.r_valid && req.r_ready) begin
            if (r_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL r_unexpected: got data %h with no beat outstanding", resp.r.data);
            end else begin
                e = r_q.pop_front();
                check("r_id", resp.r.id, e.id);
                check("r_data", resp.r.data, e.data);
                check("r_resp", resp.r.resp, e.resp);
                check("r_last", resp.r.last, e.last);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] burst;
        int size, len, bad;
        logic [31:0] addr;
        logic [5:0] atop;

        req = '0;
        rst_n = 1'b0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_aw_ready", resp.aw_ready, 1'b1);
        check("rst_ar_ready", resp.ar_ready, 1'b1);
        check("rst_w_ready", resp.w_ready, 1'b0);
        check("rst_b_valid", resp.b_valid, 1'b0);
        check("rst_r_valid", resp.r_valid, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write then read with latency checks
        wr_data[0] = 64'hDEADBEEF_CAFEF00D; wr_strb[0] = 8'hFF;
        do_write(32'h10, 0, 3, 2'b01, 6'd0, 4'h3, -1, 0, 1'b1);
        do_read(32'h10, 0, 3, 2'b01, 4'h5, 0, 1'b1, 1'b0);

        // INCR burst 1..4 with continuous r_ready
        for (int n = 0; n < 4; n++) begin wr_data[n] = 64'(n + 1); wr_strb[n] = 8'hFF; end
        do_write(32'h0, 3, 3, 2'b01, 6'd0, 4'h1, -1, 0, 1'b0);
        do_read(32'h0, 3, 3, 2'b01, 4'h2, 0, 1'b0, 1'b1);

        // WRAP burst at 0x18: words 3,0,1,2
        for (int n = 0; n < 4; n++) begin wr_data[n] = {$urandom, $urandom}; wr_strb[n] = 8'hFF; end
        do_write(32'h18, 3, 3, 2'b10, 6'd0, 4'h6, -1, 0, 1'b0);
        do_read(32'h18, 3, 3, 2'b10, 4'h7, 0, 1'b0, 1'b0);
        do_read(32'h0, 3, 3, 2'b01, 4'h8, 0, 1'b0, 1'b1);

        // Backpressure on B and R
        for (int n = 0; n < 2; n++) begin wr_data[n] = {$urandom, $urandom}; wr_strb[n] = 8'hFF; end
        do_write(32'h100, 1, 3, 2'b01, 6'd0, 4'h9, -1, 5, 1'b0);
        do_read(32'h100, 1, 3, 2'b01, 4'hA, 5, 1'b0, 1'b0);

        // Partial strobe then wlast mismatch
        wr_data[0] = 64'h11111111_11111111; wr_strb[0] = 8'hFF;
        do_write(32'h20, 0, 3, 2'b01, 6'd0, 4'h2, -1, 0, 1'b0);
        wr_data[0] = 64'hAAAAAAAA_BBBBBBBB; wr_strb[0] = 8'h0F;
        do_write(32'h20, 0, 3, 2'b01, 6'd0, 4'h2, -1, 0, 1'b0);
        do_read(32'h20, 0, 3, 2'b01, 4'h2, 0, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) begin wr_data[n] = 64'(100 + n); wr_strb[n] = 8'hFF; end
        do_write(32'h200, 3, 3, 2'b01, 6'd0, 4'hB, 1, 0, 1'b0);

        // Atomic write is consumed without a memory update
        wr_data[0] = 64'hFFFF0000_FFFF0000; wr_strb[0] = 8'hFF;
        do_write(32'h10, 0, 3, 2'b01, 6'h10, 4'hC, -1, 0, 1'b0);
        do_read(32'h10, 0, 3, 2'b01, 4'hC, 0, 1'b0, 1'b0);

        // Address beyond the array
        do_read(32'h800, 0, 3, 2'b01, 4'hD, 0, 1'b0, 1'b0);

        // Randomized mix
        for (int t = 0; t < 40; t++) begin
            burst = 2'($urandom_range(0, 2));
            size = $urandom_range(0, 3);
            if (burst == 2'b10) len = (2 << $urandom_range(0, 3)) - 1;
            else len = $urandom_range(0, 15);
            addr = 32'($urandom_range(0, MEM_BYTES + 255)) & ~((32'd1 << size) - 32'd1);
            if ($urandom_range(0, 1) == 1) begin
                for (int n = 0; n <= len; n++) begin
                    wr_data[n] = {$urandom, $urandom};
                    wr_strb[n] = 8'($urandom);
                end
                atop = ($urandom_range(0, 9) == 0) ? 6'h10 : 6'd0;
                bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
                do_write(addr, len, size, burst, atop, 4'($urandom), bad, $urandom_range(0, 2), 1'b0);
            end else begin
                do_read(addr, len, size, burst, 4'($urandom), 0, 1'b0, 1'b0);
            end
        end

        // Reset in the middle of a write burst
        req.aw = '0;
        req.aw.addr = 32'h40; req.aw.len = 8'd3; req.aw.size = 3'd3; req.aw.burst = 2'b01;
        req.aw_valid = 1'b1;
        wait_neg(0, "aw_handshake_rst");
        req.aw_valid = 1'b0;
        req.w.data = 64'h12345678_9ABCDEF0; req.w.strb = 8'hFF; req.w.last = 1'b0;
        req.w_valid = 1'b1;
        wait_neg(1, "w_handshake_rst");
        rst_n = 1'b0;
        req.w_valid = 1'b0;
        #1;
        check("midrst_aw_ready", resp.aw_ready, 1'b1);
        check("midrst_w_ready", resp.w_ready, 1'b0);
        check("midrst_b_valid", resp.b_valid, 1'b0);
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'd0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("midrst_no_b", resp.b_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        do_read(32'h40, 0, 3, 2'b01, 4'h1, 0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        check("b_queue_drained", 64'(b_q.size()), 64'd0);
        check("r_queue_drained", 64'(r_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI4 subordinate endpoint that terminates one crossbar master port and serves it from an internal flip-flop memory array. It accepts AW/W/B and AR/R traffic using the same request/response struct types as the crossbar master ports. Write and read paths run as independent state machines, each handling one burst at a time. It is the responder used for scratchpads, boot ROM stand-ins and crossbar verification targets.

## Interface
- AxiAddrWidth, 32: address width of the request struct.
- AxiDataWidth, 64: data width; StrbWidth = AxiDataWidth/8, a power of two.
- AxiIdWidth, 4: ID width; must equal the crossbar master-port ID width.
- NumWords, 256: memory depth in data words, a power of two ≥ 2.
- req_t, logic: AXI4+ATOP request struct (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready).
- resp_t, logic: AXI4+ATOP response struct (aw_ready, ar_ready, w_ready, b_valid, b, r_valid, r).
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- axi_req_i  input  $bits(req_t)  requests from the crossbar master port.
- axi_resp_o  output  $bits(resp_t)  responses to the crossbar master port.

## Operation
- Word index = addr[log2(StrbWidth) +: log2(NumWords)]; byte lane writes are gated by w.strb.
- Burst types:
  - FIXED: the address is held for every beat.
  - INCR: the address advances by 2^size bytes per beat.
  - WRAP: the address advances as INCR, wrapping within an aligned window of (len+1)·2^size bytes.
- Beat count is len+1, with a maximum of 256 beats.
- Write FSM:
  - W_IDLE: aw_ready=1. An AW handshake latches id, addr, len, size, burst and goes to W_DATA.
  - W_DATA: w_ready=1. Each W handshake writes memory and advances the address. The final counted beat goes to W_RESP.
  - W_RESP: b_valid=1, b.id = latched id. The b_ready handshake returns to W_IDLE.
- Read FSM:
  - R_IDLE: ar_ready=1. An AR handshake latches the fields and goes to R_DATA.
  - R_DATA: r_valid=1, r.data = mem[current word] (combinational read), r.id = latched id, r.last on the final beat. Each r_ready handshake advances the address. The last beat returns to R_IDLE.
- The beat counter is authoritative.
  - If w.last disagrees with the counter on any beat, b.resp = SLVERR.
  - Otherwise b.resp = OKAY, unless an error is raised under Configuration.
- AW with atop != 0: no memory update, W beats are consumed, b.resp = SLVERR. Atomics with read responses (atop[5]=1) are not supported; an atop filter sits upstream.
- r.resp = OKAY unless an error is raised under Configuration. All user fields are driven to '0.

## Timing
- Reset values:
  - aw_ready=1, ar_ready=1, w_ready=0, b_valid=0, r_valid=0.
  - Both FSMs idle, all counters 0, memory cleared to 0.
- Write latency: AW handshake in cycle N; first W accepted in cycle N+1 at the earliest. Last W handshake in cycle M; b_valid in cycle M+1.
- Read latency: AR handshake in cycle N; first R beat valid in cycle N+1. One beat per cycle under continuous r_ready.
- Valid/ready rules:
  - b_valid and r_valid, with their payloads, stay stable until the handshake completes.
  - Ready is never conditioned on the same-channel valid.
- Simultaneous write and read of the same word in one cycle: R returns the pre-write value. The new value is visible from the next cycle.
- A new AW is not accepted until B completes; a new AR is not accepted until the R last handshake.
- Reset asserted mid-burst: both FSMs return to idle immediately, the transaction is discarded, and no B or R is issued.

## Configuration
- AXI_MEM_RESPONDER_RANGE_ERR_EN:
  - Defined: each beat whose byte address ≥ NumWords·StrbWidth is flagged.
    - A flagged write beat does not update memory and forces b.resp = SLVERR.
    - A flagged read beat returns r.data = '0 with r.resp = SLVERR.
  - Undefined: addresses wrap modulo NumWords·StrbWidth, and all responses are OKAY except the wlast and atop cases above.

## Test plan
- Single write, then read: AW addr 0x10, len 0, size 3, data 0xDEADBEEF_CAFEF00D, strb 0xFF → B OKAY at M+1; AR to the same address → R data matches, last=1, OKAY, valid at N+1.
- INCR burst: write len 3 from 0x0 with data 1..4 → read back 1..4; r.last only on beat 4.
- WRAP burst: write len 3, size 3, at addr 0x18 → words 3,0,1,2 written; a read with the same parameters returns the data in the same order.
- Backpressure: b_ready and r_ready held low for 5 cycles → b_valid, r_valid and payloads stay stable; no new AW or AR is accepted.
- Errors:
  - Strb 0x0F write → only the low 4 bytes change.
  - w.last asserted on beat 2 of a len=3 burst → b.resp SLVERR.
- With RANGE_ERR_EN, NumWords=256: read at 0x800 → R SLVERR, data 0. Without the macro, the same read returns word 0.
